// File: rtl/systolic_pkg.sv
// Shared op codes, FSM state encoding and dataflow mode constants for the systolic controller.
package systolic_pkg;

    // Broadcast PE operation codes
    localparam logic [2:0] OP_W_LOAD   = 3'b001;
    localparam logic [2:0] OP_W_FLOW   = 3'b000;
    localparam logic [2:0] OP_OS_FLOW  = 3'b100;
    localparam logic [2:0] OP_OS_DRAIN = 3'b110;

    // Dataflow modes
    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        WFLOW,
        OS_CLR,
        OS_FLOW,
        OS_DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/phase_cnt.sv
// Loadable phase up-counter with terminal-count compare against a per-phase limit.
module phase_cnt #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt_c,
    output logic         tc_c
);

    // Next count: reload to zero on phase entry, otherwise advance when enabled
    always_comb begin
        count_nxt_c = count;
        if (clr) begin
            count_nxt_c = '0;
        end else if (en) begin
            count_nxt_c = count + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_nxt_c;
        end
    end

    assign tc_c = (count == term);

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for a ROWS x COLS systolic array: weight-stationary or output-stationary flow.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [CNT_WIDTH-1:0] k_len,
    input  logic                 abort,
    output logic [2:0]           operation_signal_out,
    output logic                 acc_clear,
    output logic                 wgt_rd_en,
    output logic                 act_rd_en,
    output logic                 out_wr_en,
    output logic                 busy,
    output logic                 done
);

    // One extra bit so k_len+ROWS+COLS cannot wrap
    localparam int unsigned CW = CNT_WIDTH + 1;

    state_t               state, state_nxt;
    logic                 mode_q, mode_nxt;
    logic [CNT_WIDTH-1:0] k_q, k_nxt;
    logic [CW-1:0]        k_ext, k_ext_nxt;
    logic [CW-1:0]        term, cnt, cnt_nxt;
    logic                 tc;

    logic [2:0]           op_d;
    logic                 clr_d, wgt_d, act_d, out_d, busy_d, done_d;

    assign k_ext     = CW'(k_q);
    assign k_ext_nxt = CW'(k_nxt);

    // Terminal count (phase length - 1) for the current state
    always_comb begin
        term = '0;
        case (state)
            WLOAD:    term = CW'(ROWS - 1);
            WFLOW:    term = k_ext + CW'(ROWS + COLS - 2);
            OS_FLOW:  term = k_ext + CW'(ROWS + COLS - 3);
            OS_DRAIN: term = CW'(ROWS - 1);
            default:  term = '0;
        endcase
    end

    phase_cnt #(
        .W (CW)
    ) u_phase_cnt (
        .clk         (clk),
        .reset       (reset),
        .clr         (state_nxt != state),
        .en          (state_nxt != IDLE),
        .term        (term),
        .count       (cnt),
        .count_nxt_c (cnt_nxt),
        .tc_c        (tc)
    );

    // Next state and job latch; abort from any busy state wins over every other move
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        k_nxt     = k_q;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_nxt = mode;
                    k_nxt    = k_len;
                    if (k_len == '0) begin
                        state_nxt = DONE;
                    end else if (mode == MODE_OS) begin
                        state_nxt = OS_CLR;
                    end else begin
                        state_nxt = WLOAD;
                    end
                end
            end
            WLOAD:    if (tc) state_nxt = WFLOW;
            WFLOW:    if (tc) state_nxt = DONE;
            OS_CLR:   if (tc) state_nxt = OS_FLOW;
            OS_FLOW:  if (tc) state_nxt = OS_DRAIN;
            OS_DRAIN: if (tc) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // Moore decode of the upcoming state/phase count, so outputs register alongside state
    always_comb begin
        op_d   = OP_W_FLOW;
        clr_d  = 1'b0;
        wgt_d  = 1'b0;
        act_d  = 1'b0;
        out_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_nxt)
            WLOAD: begin
                op_d   = OP_W_LOAD;
                wgt_d  = 1'b1;
                busy_d = 1'b1;
            end
            WFLOW: begin
                busy_d = 1'b1;
                act_d  = (cnt_nxt < k_ext_nxt);
                out_d  = (cnt_nxt >= CW'(ROWS + COLS - 1));
            end
            OS_CLR: begin
                op_d   = OP_OS_FLOW;
                clr_d  = 1'b1;
                busy_d = 1'b1;
            end
            OS_FLOW: begin
                op_d   = OP_OS_FLOW;
                busy_d = 1'b1;
                act_d  = (cnt_nxt < k_ext_nxt);
                wgt_d  = (cnt_nxt < k_ext_nxt);
            end
            OS_DRAIN: begin
                op_d   = OP_OS_DRAIN;
                out_d  = 1'b1;
                busy_d = 1'b1;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, job latch and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            mode_q               <= MODE_WS;
            k_q                  <= '0;
            operation_signal_out <= 3'b000;
            acc_clear            <= 1'b0;
            wgt_rd_en            <= 1'b0;
            act_rd_en            <= 1'b0;
            out_wr_en            <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            state                <= state_nxt;
            mode_q               <= mode_nxt;
            k_q                  <= k_nxt;
            operation_signal_out <= op_d;
            acc_clear            <= clr_d;
            wgt_rd_en            <= wgt_d;
            act_rd_en            <= act_d;
            out_wr_en            <= out_d;
            busy                 <= busy_d;
            done                 <= done_d;
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: per-cycle expected output vectors queued at job start.
module tb_systolic_ctrl;

    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int CNT_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 mode;
    logic [CNT_WIDTH-1:0] k_len;
    logic                 abort;
    logic [2:0]           operation_signal_out;
    logic                 acc_clear, wgt_rd_en, act_rd_en, out_wr_en, busy, done;

    logic [8:0]           obs;
    logic [8:0]           sb_q[$];
    int                   n_cmp  = 0;
    int                   n_fail = 0;

    systolic_ctrl #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .mode                 (mode),
        .k_len                (k_len),
        .abort                (abort),
        .operation_signal_out (operation_signal_out),
        .acc_clear            (acc_clear),
        .wgt_rd_en            (wgt_rd_en),
        .act_rd_en            (act_rd_en),
        .out_wr_en            (out_wr_en),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    assign obs = {operation_signal_out, acc_clear, wgt_rd_en, act_rd_en, out_wr_en, busy, done};

    // Expected {op, acc_clear, wgt, act, out_wr, busy, done} in cycle c (1 = first cycle after start edge)
    function automatic logic [8:0] model(input logic m, input int k, input int c);
        logic [2:0] op = 3'b000;
        logic clr = 1'b0, w = 1'b0, a = 1'b0, o = 1'b0, b = 1'b0, d = 1'b0;
        int lf = k + ROWS + COLS - 1;
        int lo = k + ROWS + COLS - 2;
        if (k == 0) begin
            if (c == 1) begin b = 1'b1; d = 1'b1; end
        end else if (!m) begin
            if (c >= 1 && c <= ROWS) begin
                op = 3'b001; w = 1'b1; b = 1'b1;
            end else if (c > ROWS && c <= ROWS + lf) begin
                b = 1'b1;
                a = (c <= ROWS + k);
                o = (c > ROWS + lf - k);
            end else if (c == ROWS + lf + 1) begin
                b = 1'b1; d = 1'b1;
            end
        end else begin
            if (c == 1) begin
                op = 3'b100; clr = 1'b1; b = 1'b1;
            end else if (c >= 2 && c <= 1 + lo) begin
                op = 3'b100; b = 1'b1;
                a = (c <= 1 + k);
                w = (c <= 1 + k);
            end else if (c > 1 + lo && c <= 1 + lo + ROWS) begin
                op = 3'b110; o = 1'b1; b = 1'b1;
            end else if (c == 2 + lo + ROWS) begin
                b = 1'b1; d = 1'b1;
            end
        end
        return {op, clr, w, a, o, b, d};
    endfunction

    function automatic int job_len(input logic m, input int k);
        if (k == 0) return 1;
        if (!m) return ROWS + (k + ROWS + COLS - 1) + 1;
        return 2 + (k + ROWS + COLS - 2) + ROWS;
    endfunction

    task automatic check(input string tag, input int c, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, o, e);
        end
    endtask

    // Call at a negedge: launch a job, queue its expected trace, then compare every cycle
    task automatic run_job(input string tag, input logic m, input int k,
                           input int abort_at, input int restart_at, input logic abort_with_start);
        int n;
        int dones;
        logic [8:0] e;
        n     = job_len(m, k) + 2;
        dones = 0;
        start = 1'b1;
        mode  = m;
        k_len = CNT_WIDTH'(k);
        abort = abort_with_start;
        for (int c = 1; c <= n; c++) begin
            sb_q.push_back((abort_at > 0 && c > abort_at) ? 9'h000 : model(m, k, c));
        end
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            e = sb_q.pop_front();
            check(tag, c, 32'(obs), 32'(e));
            dones += int'(done);
            if (c == abort_at)   abort = 1'b1;
            if (c == restart_at) begin
                start = 1'b1;
                mode  = ~m;
                k_len = CNT_WIDTH'(7);
            end
        end
        check({tag, "_done_count"}, 0, 32'(dones), (abort_at > 0) ? 32'd0 : 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        k_len = '0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 0, 32'(obs), 32'd0);

        // First edge after reset release accepts the job
        @(negedge clk);
        reset = 1'b0;
        run_job("ws_k3", 1'b0, 3, 0, 0, 1'b0);
        @(negedge clk);
        run_job("os_k3", 1'b1, 3, 0, 0, 1'b0);
        @(negedge clk);
        run_job("ws_restart", 1'b0, 3, 0, 6, 1'b0);
        @(negedge clk);
        run_job("ws_k0", 1'b0, 0, 0, 0, 1'b0);
        @(negedge clk);
        run_job("os_k0", 1'b1, 0, 0, 0, 1'b0);
        @(negedge clk);
        run_job("os_abort", 1'b1, 3, 8, 0, 1'b0);
        @(negedge clk);
        run_job("ws_after_abort", 1'b0, 1, 0, 0, 1'b0);
        @(negedge clk);
        run_job("os_start_abort", 1'b1, 2, 0, 0, 1'b1);
        @(negedge clk);
        run_job("ws_k5", 1'b0, 5, 0, 0, 1'b0);
        @(negedge clk);
        run_job("os_k1", 1'b1, 1, 0, 0, 1'b0);

        // Abort while idle is a no-op
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("idle_abort", 0, 32'(obs), 32'd0);

        // Asynchronous reset in the middle of WFLOW
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        k_len = CNT_WIDTH'(3);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            check("ws_pre_reset", c, 32'(obs), 32'(model(1'b0, 3, c)));
        end
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 0, 32'(obs), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            check("held_reset", c, 32'(obs), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        run_job("os_after_reset", 1'b1, 2, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameters SHALL be: ROWS, default 4, PE array rows; COLS, default 4, PE array columns; CNT_WIDTH, default 16, width of k_len and internal phase counters.
REQ-002 Ports SHALL be: clk, in, 1, single clock; rising edge only.
REQ-003 Ports SHALL be: reset, in, 1, asynchronous, active-high.
REQ-004 Ports SHALL be: start, in, 1, job request, sampled only in IDLE.
REQ-005 Ports SHALL be: mode, in, 1, 0 = weight-stationary (WS), 1 = output-stationary (OS); latched on start.
REQ-006 Ports SHALL be: k_len, in, CNT_WIDTH, reduction length in cycles; latched on start.
REQ-007 Ports SHALL be: abort, in, 1, synchronous job cancel.
REQ-008 Ports SHALL be: operation_signal_out, out, 3, broadcast PE operation code.
REQ-009 Ports SHALL be: acc_clear, out, 1, PE accumulator clear, ORed into the array reset.
REQ-010 Ports SHALL be: wgt_rd_en, act_rd_en, out_wr_en, out, 1 each, buffer strobes.
REQ-011 Ports SHALL be: busy, out, 1, high in every state except IDLE; done, out, 1, one-cycle completion pulse.

Function
REQ-012 Op codes SHALL be: W_LOAD 3'b001, W_FLOW 3'b000, OS_FLOW 3'b100, OS_DRAIN 3'b110.
REQ-013 FSM states SHALL be: IDLE, WLOAD, WFLOW, OS_CLR, OS_FLOW, OS_DRAIN, DONE.
REQ-014 All outputs SHALL be Moore-decoded from the registered state and phase counter; there is no combinational path from any input to any output.
REQ-015 start=1 in IDLE at edge E0 SHALL latch mode and k_len; the first job cycle is the cycle after E0.
REQ-016 start while busy SHALL be ignored, with no queuing.
REQ-017 WS path: WLOAD lasts ROWS cycles (op=W_LOAD, wgt_rd_en=1), then WFLOW.
REQ-018 WFLOW SHALL last k_len+ROWS+COLS-1 cycles with op=W_FLOW; act_rd_en=1 in its first k_len cycles; out_wr_en=1 in its last k_len cycles; then DONE.
REQ-019 OS path: OS_CLR lasts 1 cycle (acc_clear=1, op=OS_FLOW, all strobes 0), then OS_FLOW.
REQ-020 OS_FLOW SHALL last k_len+ROWS+COLS-2 cycles with op=OS_FLOW; act_rd_en=wgt_rd_en=1 in its first k_len cycles; then OS_DRAIN.
REQ-021 OS_DRAIN SHALL last ROWS cycles with op=OS_DRAIN and out_wr_en=1; then DONE.
REQ-022 DONE SHALL last 1 cycle with done=1, busy=1, op=W_FLOW, all strobes 0; then IDLE.
REQ-023 In IDLE: op=W_FLOW, acc_clear=0, all strobes 0, busy=0.
REQ-024 k_len=0 at start SHALL go directly IDLE->DONE: done pulses in the 1st cycle after E0, with no array operation issued.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with no done pulse; abort in IDLE has no effect.
REQ-026 abort takes priority over every other transition, including DONE->IDLE.
REQ-027 start and abort both high in IDLE: the start SHALL be accepted.
REQ-028 Phase counters SHALL be CNT_WIDTH+1 bits so that k_len+ROWS+COLS never wraps.
REQ-029 Each counter SHALL reload to 0 on every state entry.

Reset
REQ-030 reset=1 SHALL asynchronously force state=IDLE, counters=0, latched mode/k_len=0, op=3'b000, acc_clear=0, all strobes=0, busy=0, done=0.
REQ-031 Reset mid-job SHALL discard the job with no done pulse.
REQ-032 The first job is accepted at the first edge after reset deasserts with start=1.

Structure
REQ-033 Package systolic_pkg SHALL hold: the op-code constants, the FSM state encoding, and MODE_WS=0 / MODE_OS=1.
REQ-034 A sub-module phase_cnt SHALL be used: loadable up-counter with a terminal-count compare, instantiated once.

Verification (ROWS=COLS=4)
REQ-035 WS, k_len=3, start at E0: op=001 for cycles 1-4, wgt_rd_en high cycles 1-4; op=000 for cycles 5-14, act_rd_en cycles 5-7, out_wr_en cycles 12-14; done in cycle 15; busy=0 in cycle 16.
REQ-036 OS, k_len=3: acc_clear in cycle 1; op=100 in cycles 1-10, act_rd_en/wgt_rd_en cycles 2-4; op=110 with out_wr_en in cycles 11-14; done in cycle 15.
REQ-037 k_len=0, either mode: done in cycle 1, all strobes 0 throughout, busy=0 in cycle 2.
REQ-038 start pulsed again in cycle 6 of a WS job: ignored, and done occurs exactly once in cycle 15.
REQ-039 abort in cycle 8 of an OS job: IDLE in cycle 9, outputs at idle values, done never asserted; a new start is then accepted.
REQ-040 reset asserted asynchronously mid-WFLOW: outputs go to their reset values immediately without waiting for a clock edge; no done pulse.
